spi_mode_config: RTL and testbench

- Converts a free-running raw SPI bit clock (sclk_raw, idle-low, produced by the clock divider) into a mode-correct SCLK for the pad.
- Also produces single-cycle capture_edge and shift_edge strobes in the system clock domain, per SPI mode (CPOL/CPHA).
- Sits between the SCLK divider and the shift-register/datapath of the SPI master.

---
 rtl/spi_mode_config.sv | 71 +++++++
 tb/tb_spi_mode_config.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_mode_config.sv
// SPI mode adapter: synchronises the raw divider clock and derives a polarity-correct
// SCLK plus one-cycle capture/shift strobes for the selected CPOL/CPHA mode.
module spi_mode_config #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_raw,
  input  logic cpol,
  input  logic cpha,
  output logic sclk,
  output logic capture_edge,
  output logic shift_edge
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   sclk_q, sclk_d;
  logic                   cap_q, cap_d;
  logic                   shift_q, shift_d;

  logic sync, rise, fall, raw_idle;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], sclk_raw};

  always_comb begin
    sync     = sync_q[SYNC_STAGES-1];
    rise     = sync & ~prev_q;
    fall     = ~sync & prev_q;
    raw_idle = ~sync & ~prev_q;

    // Mode only updates while the raw clock is settled low, so SCLK never glitches mid-pulse.
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    if (raw_idle) begin
      cpol_d = cpol;
      cpha_d = cpha;
    end

    sclk_d  = sync ^ cpol_q;
    cap_d   = cpha_q ? fall : rise;
    shift_d = cpha_q ? rise : fall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cap_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= sync;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      cap_q   <= cap_d;
      shift_q <= shift_d;
    end
  end

  assign sclk         = sclk_q;
  assign capture_edge = cap_q;
  assign shift_edge   = shift_q;

endmodule

// File: tb/tb_spi_mode_config.sv
// Bench for spi_mode_config: delayed-sample reference model checked every cycle,
// directed latency/mode/deferral/reset cases, then randomized raw clock and mode changes.
module tb_spi_mode_config;
  localparam int unsigned D = 2;

  logic clk      = 1'b1;
  logic reset    = 1'b0;
  logic sclk_raw = 1'b0;
  logic cpol     = 1'b0;
  logic cpha     = 1'b0;
  logic sclk, capture_edge, shift_edge;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_mode_config #(.SYNC_STAGES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_raw     (sclk_raw),
    .cpol         (cpol),
    .cpha         (cpha),
    .sclk         (sclk),
    .capture_edge (capture_edge),
    .shift_edge   (shift_edge)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: h[k] holds the raw level sampled k+1 edges ago; the design sees the raw
  // clock D edges late, the mode latches on two consecutive low views.
  bit h [0:D];
  bit cpol_m, cpha_m;
  initial begin
    bit sy, pv, rs, fl, e_s, e_c, e_f;
    for (int i = 0; i <= int'(D); i++) h[i] = 1'b0;
    cpol_m = 1'b0; cpha_m = 1'b0;
    e_s = 1'b0; e_c = 1'b0; e_f = 1'b0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        for (int i = 0; i <= int'(D); i++) h[i] = 1'b0;
        cpol_m = 1'b0; cpha_m = 1'b0;
        e_s = 1'b0; e_c = 1'b0; e_f = 1'b0;
      end else begin
        sy  = h[D-1];
        pv  = h[D];
        rs  = sy & ~pv;
        fl  = ~sy & pv;
        e_s = sy ^ cpol_m;
        e_c = cpha_m ? fl : rs;
        e_f = cpha_m ? rs : fl;
        if (!sy && !pv) begin
          cpol_m = cpol;
          cpha_m = cpha;
        end
        for (int i = int'(D); i > 0; i--) h[i] = h[i-1];
        h[0] = sclk_raw;
      end
      #1;
      check("sclk", sclk, e_s);
      check("capture_edge", capture_edge, e_c);
      check("shift_edge", shift_edge, e_f);
      check("exclusive", capture_edge & shift_edge, 1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic toggle(input int periods, input int hi, input int lo);
    for (int p = 0; p < periods; p++) begin
      sclk_raw = 1'b1; cyc(hi);
      sclk_raw = 1'b0; cyc(lo);
    end
  endtask

  initial begin
    #12;
    check("reset_sclk", sclk, 1'b0);
    check("reset_cap", capture_edge, 1'b0);
    check("reset_shift", shift_edge, 1'b0);
    #3 reset = 1'b1;
    cyc(4);
    check("settle_sclk", sclk, 1'b0);

    // Mode 0, 40 ns raw period
    toggle(6, 2, 2);

    // Latency pin: raw rise sampled at edge k shows up after edge k+2
    sclk_raw = 1'b0; cyc(5);
    sclk_raw = 1'b1; cyc(2);
    check("lat_before", sclk, 1'b0);
    cyc(1);
    check("lat_sclk", sclk, 1'b1);
    check("lat_cap", capture_edge, 1'b1);
    cyc(1);
    check("lat_width", capture_edge, 1'b0);
    sclk_raw = 1'b0; cyc(3);
    check("lat_fall", sclk, 1'b0);
    check("lat_shift", shift_edge, 1'b1);

    // Mode 1, 2, 3 set while raw low
    for (int m = 1; m < 4; m++) begin
      cyc(4);
      {cpol, cpha} = 2'(m);
      cyc(4);
      if (m == 2) begin
        check("cpol1_idle", sclk, 1'b1);
        sclk_raw = 1'b1; cyc(3);
        check("cpol1_lead", sclk, 1'b0);
        check("cpol1_cap", capture_edge, 1'b1);
        sclk_raw = 1'b0; cyc(4);
      end
      toggle(6, 2, 2);
    end

    // cpol toggled during raw high is deferred to the next low phase
    cpol = 1'b0; cpha = 1'b0; cyc(6);
    sclk_raw = 1'b1; cyc(4);
    check("defer_hi", sclk, 1'b1);
    cpol = 1'b1; cyc(4);
    check("defer_hold", sclk, 1'b1);
    sclk_raw = 1'b0; cyc(3);
    check("defer_low", sclk, 1'b0);
    check("defer_shift", shift_edge, 1'b1);
    cyc(2);
    check("defer_new", sclk, 1'b1);

    // Asynchronous reset while a capture strobe is high
    cpol = 1'b1; cpha = 1'b0; cyc(6);
    sclk_raw = 1'b1; cyc(3);
    check("arst_pre_cap", capture_edge, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("arst_sclk", sclk, 1'b0);
    check("arst_cap", capture_edge, 1'b0);
    check("arst_shift", shift_edge, 1'b0);
    sclk_raw = 1'b0; cyc(3);
    #3 reset = 1'b1;
    cyc(3);
    check("arst_recover", sclk, 1'b1);

    // Randomized raw phases with mode changes at arbitrary points
    repeat (300) begin
      int hi, lo;
      hi = int'($urandom_range(D + 4, D + 1));
      lo = int'($urandom_range(D + 4, D + 1));
      sclk_raw = 1'b1;
      for (int i = 0; i < hi; i++) begin
        if ($urandom_range(7) == 0) {cpol, cpha} = 2'($urandom_range(3));
        cyc(1);
      end
      sclk_raw = 1'b0;
      for (int i = 0; i < lo; i++) begin
        if ($urandom_range(7) == 0) {cpol, cpha} = 2'($urandom_range(3));
        cyc(1);
      end
    end
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
